wide_add_sequencer: RTL and testbench
=====================================

# wide_add_sequencer

Multi-cycle wide add/subtract unit that reuses one narrow prefix-adder slice over several cycles. It accepts WIDTH-bit operands through a valid/ready handshake and feeds them to the slice SLICE bits per cycle, least-significant slice first. The carry between slices is held in a register. The final sum, carry-out and signed overflow are returned through a second valid/ready handshake. It sits between an operand source (ALU issue logic) and a result consumer, and trades latency for adder area.

## Interface
- WIDTH, 64, operand/result width; must be an integer multiple of SLICE.
- SLICE, 16, bits processed per cycle by the slice adder.
- NSLICE, WIDTH/SLICE, derived (localparam); must be >= 2. Elaboration error otherwise.
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand request
- in_ready  out  1  unit can accept an operand
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0 = A+B, 1 = A−B (computed as A + ~B + 1)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB; for subtract, 1 = no borrow (A ≥ B unsigned)
- ovf  out  1  two's-complement overflow

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch a, b ^ {WIDTH{sub}} and carry = sub.
  - Clear slice counter k to 0, then go to RUN.
- RUN:
  - Each cycle, the slice adder computes a[k] + b'[k] + carry, where [k] is bits k·SLICE+SLICE−1 : k·SLICE.
  - Write the slice result into sum[k], load carry with the slice carry-out, then increment k.
  - On the last slice (k = NSLICE−1):
    - cout ← slice carry-out.
    - ovf ← (a_msb == b'_msb) & (result_msb != a_msb).
    - Go to DONE.
- DONE:
  - out_valid = 1.
  - On out_ready, go to IDLE.
- in_ready = 0 in RUN and DONE, and whenever rst = 1. in_valid is ignored outside IDLE.
- No operand bypass: a, b and sub are sampled only on the accept edge. Later changes on them have no effect.
- Outputs sum, cout and ovf are meaningful only while out_valid = 1. From entry to DONE until the next RUN begins, they are held stable.
- Carry register and slice counter are internal. k wraps to 0 only via a new accept.

## Timing
- Reset values (asynchronous): state IDLE, out_valid 0, sum 0, cout 0, ovf 0, carry 0, k 0, in_ready 0 while rst is high.
- Let E0 be the accept edge. RUN occupies the NSLICE cycles after E0. out_valid rises in the cycle after edge E0+NSLICE, which is NSLICE cycles of latency.
- Output handshake completes at the edge where out_valid & out_ready. in_ready is 1 in the following cycle.
- Minimum issue interval is NSLICE+2 cycles (IDLE accept, NSLICE RUN, one DONE cycle).
- With out_ready held low, the FSM stays in DONE indefinitely with outputs frozen. There is no timeout.
- If rst asserts mid-RUN or in DONE, the operation is abandoned and all outputs return to reset values immediately. No partial result is ever delivered.
- If in_valid and rst release in the same cycle, nothing is accepted until the first edge after rst deasserts.

## Structure
- Shared package `wide_add_pkg`:
  - state enum {IDLE, RUN, DONE};
  - default SLICE constant;
  - slice-count function.
- Sub-module `seq_slice_adder`:
  - parameter W (= SLICE);
  - inputs a, b, cin; outputs s, cout;
  - combinational Kogge–Stone prefix adder.
  - Instantiated once; the sequencer holds all state.

## Test plan
1. Add, WIDTH=64: a=FFFF_FFFF_FFFF_FFFF, b=1, sub=0.
   - Expect sum=0, cout=1, ovf=0.
   - out_valid rises exactly 4 cycles after the accept edge.
2. Subtract: a=5, b=7, sub=1.
   - Expect sum=FFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
   - Also a=7, b=5: expect sum=2, cout=1.
3. Signed overflow: a=7FFF_FFFF_FFFF_FFFF, b=1, sub=0.
   - Expect sum=8000_0000_0000_0000, cout=0, ovf=1.
4. Inter-slice carry: a=0000_0000_0000_FFFF, b=1.
   - Expect sum=0000_0000_0001_0000, cout=0.
   - Issue back-to-back with out_ready=1: second accept happens exactly NSLICE+2 cycles after the first.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid, toggling a, b and in_valid meanwhile.
   - Expect out_valid=1, in_ready=0, and sum/cout/ovf unchanged throughout.
   - The result is delivered once out_ready=1.
6. Reset mid-RUN: assert rst while k=2.
   - Expect out_valid=0 and sum=0 immediately.
   - After release, a=DEAD_BEEF_DEAD_BEEF, b=1111_1111_1111_1111 gives sum=EFBE_D000_EFBE_D000, cout=0, ovf=0.

Source files
------------

// File: rtl/wide_add_pkg.sv
// Shared definitions for the wide add/subtract sequencer.
//
// Contents:
//   DEFAULT_SLICE : default number of bits handled by the slice adder per cycle
//   seq_state_t   : sequencer states (IDLE, RUN, DONE)
//   slice_count() : number of slices needed to cover a given operand width
package wide_add_pkg;

    localparam int DEFAULT_SLICE = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    function automatic int slice_count(input int width, input int slice);
        return width / slice;
    endfunction

endpackage

// File: rtl/seq_slice_adder.sv
// Combinational W-bit Kogge-Stone prefix adder used as the single reusable
// slice inside the wide add sequencer.
//
// Ports:
//   a, b  in  W  addends
//   cin   in  1  carry into bit 0
//   s     out W  sum
//   cout  out 1  carry out of bit W-1
module seq_slice_adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W-1:0] prop;
    logic [W-1:0] gen;
    logic [W-1:0] grp_g;
    logic [W-1:0] grp_p;
    logic [W-1:0] next_g;
    logic [W-1:0] next_p;
    logic [W-1:0] carry_in;

    // Prefix tree: after the level with span d, grp_g[i]/grp_p[i] describe the
    // group of bits i down to max(0, i-2d+1). Once all levels are done, each
    // position covers bits i..0, so the carry into bit i+1 is just that group
    // generate OR'd with the group propagate gated by cin.
    always_comb begin
        prop     = a ^ b;
        gen      = a & b;
        grp_g    = gen;
        grp_p    = prop;
        next_g   = '0;
        next_p   = '0;
        carry_in = '0;
        for (int d = 1; d < W; d = d * 2) begin
            next_g = grp_g;
            next_p = grp_p;
            for (int i = d; i < W; i++) begin
                next_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
                next_p[i] = grp_p[i] & grp_p[i-d];
            end
            grp_g = next_g;
            grp_p = next_p;
        end
        carry_in[0] = cin;
        for (int i = 1; i < W; i++) begin
            carry_in[i] = grp_g[i-1] | (grp_p[i-1] & cin);
        end
        s    = prop ^ carry_in;
        cout = grp_g[W-1] | (grp_p[W-1] & cin);
    end

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract unit. Operands are accepted through a
// valid/ready handshake and pushed through one SLICE-bit adder, least
// significant slice first, with the inter-slice carry held in a register.
// The finished sum, carry-out and signed overflow are returned through a
// second valid/ready handshake.
//
// Ports:
//   clk        in  1      clock, rising edge
//   rst        in  1      asynchronous active-high reset
//   in_valid   in  1      operand request
//   in_ready   out 1      unit can accept an operand (IDLE and not in reset)
//   a, b       in  WIDTH  operands
//   sub        in  1      0 = a+b, 1 = a-b
//   out_valid  out 1      result available (DONE)
//   out_ready  in  1      consumer takes the result
//   sum        out WIDTH  result
//   cout       out 1      carry out of MSB (subtract: 1 = no borrow)
//   ovf        out 1      two's-complement overflow
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = slice_count(WIDTH, SLICE);
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (((WIDTH % SLICE) != 0) || (NSLICE < 2)) begin : g_param_check
        $error("wide_add_sequencer: WIDTH must be a multiple of SLICE giving at least two slices");
    end

    seq_state_t       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_s;
    logic             slice_cout;
    logic             last_slice;

    // b_q already holds the inverted operand for subtract, so the slice adder
    // only ever adds; the +1 of the two's complement rides in on carry_q.
    assign slice_a    = a_q[int'(k_q)*SLICE +: SLICE];
    assign slice_b    = b_q[int'(k_q)*SLICE +: SLICE];
    assign last_slice = (k_q == KW'(NSLICE - 1));

    seq_slice_adder #(
        .W(SLICE)
    ) u_slice (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry_q),
        .s   (slice_s),
        .cout(slice_cout)
    );

    // Handshake outputs come straight from the state; in_ready is also masked
    // by rst so nothing can look acceptable while the unit is held in reset.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // Sequencer: capture operands on accept, walk the slices in RUN, then hold
    // the result untouched in DONE until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= sub;
                        k_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[int'(k_q)*SLICE +: SLICE] <= slice_s;
                    carry_q <= slice_cout;
                    k_q     <= k_q + KW'(1);
                    if (last_slice) begin
                        cout_q  <= slice_cout;
                        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                   (slice_s[SLICE-1] != a_q[WIDTH-1]);
                        k_q     <= '0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (WIDTH=64, SLICE=16).
// A cycle-level reference model predicts handshake timing and results from
// plain 64-bit arithmetic; one compare process checks the DUT against it on
// every falling edge, and directed cases pin the model with literal values.
module tb_wide_add_sequencer;

    localparam int WIDTH  = 64;
    localparam int SLICE  = 16;
    localparam int NSLICE = WIDTH / SLICE;
    localparam int PERIOD = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    wide_add_sequencer #(
        .WIDTH(WIDTH),
        .SLICE(SLICE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #(PERIOD/2) clk = ~clk;

    // Reference result {ovf, cout, sum} from ordinary integer arithmetic.
    function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic             s);
        logic [WIDTH:0]   wide;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             o;
        if (!s) begin
            wide = {1'b0, x} + {1'b0, y};
            r    = wide[WIDTH-1:0];
            c    = wide[WIDTH];
            o    = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        end else begin
            r = x - y;
            c = (x >= y);
            o = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        end
        return {o, c, r};
    endfunction

    logic [WIDTH+1:0] ref_now;
    assign ref_now = ref_op(a, b, sub);

    // Reference model: one operation in flight, result due NSLICE edges after
    // the accept edge, released on the first edge with out_ready high.
    logic             m_pending;
    longint           m_cyc;
    longint           m_ready_at;
    logic [WIDTH-1:0] m_sum;
    logic             m_cout;
    logic             m_ovf;
    logic             m_valid;

    assign m_valid = m_pending && (m_cyc >= m_ready_at);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pending  <= 1'b0;
            m_cyc      <= 0;
            m_ready_at <= 0;
            m_sum      <= '0;
            m_cout     <= 1'b0;
            m_ovf      <= 1'b0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (!m_pending) begin
                if (in_valid) begin
                    m_pending               <= 1'b1;
                    m_ready_at              <= m_cyc + NSLICE + 1;
                    {m_ovf, m_cout, m_sum}  <= ref_now;
                end
            end else if (m_valid && out_ready) begin
                m_pending <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("in_ready", {63'd0, in_ready}, {63'd0, !m_pending});
            checkOutput("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
            if (m_valid) begin
                checkOutput("sum", sum, m_sum);
                checkOutput("cout", {63'd0, cout}, {63'd0, m_cout});
                checkOutput("ovf", {63'd0, ovf}, {63'd0, m_ovf});
            end
        end
    end

    // Drive an operand at a falling edge and hold it until accepted; returns
    // at the falling edge after the accept edge with in_valid still high.
    task automatic applyStimulus(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                                 input logic op_sub, output time t_acc, output bit ok);
        ok       = 1'b0;
        t_acc    = 0;
        a        = op_a;
        b        = op_b;
        sub      = op_sub;
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (in_ready) begin
                @(posedge clk);
                t_acc = $time;
                @(negedge clk);
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        checkOutput("accept_timeout", 64'd1, 64'd0);
    endtask

    task automatic waitResult(output time t_val, output bit ok);
        ok    = 1'b0;
        t_val = 0;
        for (int n = 0; n < 4 * NSLICE + 20; n++) begin
            if (out_valid) begin
                t_val = $time;
                ok    = 1'b1;
                return;
            end
            @(negedge clk);
        end
        checkOutput("result_timeout", 64'd1, 64'd0);
    endtask

    task automatic runOp(input string name, input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                         input logic op_sub, input logic [WIDTH-1:0] exp_sum,
                         input logic exp_cout, input logic exp_ovf);
        time t_acc;
        time t_val;
        bit  ok;
        out_ready = 1'b1;
        applyStimulus(op_a, op_b, op_sub, t_acc, ok);
        in_valid = 1'b0;
        if (!ok) return;
        waitResult(t_val, ok);
        if (!ok) return;
        checkOutput({name, "_latency"}, (t_val - t_acc - PERIOD/2) / PERIOD, 64'(NSLICE));
        checkOutput({name, "_sum"}, sum, exp_sum);
        checkOutput({name, "_cout"}, {63'd0, cout}, {63'd0, exp_cout});
        checkOutput({name, "_ovf"}, {63'd0, ovf}, {63'd0, exp_ovf});
        @(negedge clk);
        checkOutput({name, "_ready_after"}, {63'd0, in_ready}, 64'd1);
    endtask

    function automatic logic [WIDTH-1:0] pick_operand();
        logic [WIDTH-1:0] v;
        case ($urandom_range(0, 11))
            0:       v = '1;
            1:       v = '0;
            2:       v = 64'h8000_0000_0000_0000;
            3:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            4:       v = 64'h0000_0000_0000_FFFF;
            default: v = {$urandom(), $urandom()};
        endcase
        return v;
    endfunction

    initial begin
        time t1;
        time t2;
        time tv;
        bit  ok;

        #2;
        checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd0);
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_sum", sum, 64'd0);
        checkOutput("rst_cout", {63'd0, cout}, 64'd0);
        checkOutput("rst_ovf", {63'd0, ovf}, 64'd0);
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("idle_in_ready", {63'd0, in_ready}, 64'd1);

        $display("[TB] directed add/subtract cases");
        runOp("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
        runOp("sub_borrow", 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        runOp("sub_pos", 64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0);
        runOp("sub_equal", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'd0, 1'b1, 1'b0);
        runOp("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);

        $display("[TB] back-to-back issue");
        out_ready = 1'b1;
        applyStimulus(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, t1, ok);
        a = 64'h1234_5678_9ABC_DEF0;
        b = 64'h0FED_CBA9_8765_4321;
        waitResult(tv, ok);
        checkOutput("b2b_first_sum", sum, 64'h0000_0000_0001_0000);
        checkOutput("b2b_first_cout", {63'd0, cout}, 64'd0);
        applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, t2, ok);
        in_valid = 1'b0;
        checkOutput("b2b_interval", (t2 - t1) / PERIOD, 64'(NSLICE + 2));
        waitResult(tv, ok);
        checkOutput("b2b_second_sum", sum, 64'h2222_2222_2222_2211);
        @(negedge clk);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, t1, ok);
        in_valid = 1'b0;
        waitResult(tv, ok);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", {63'd0, out_valid}, 64'd1);
            checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
            checkOutput("bp_sum", sum, 64'd0);
            checkOutput("bp_cout", {63'd0, cout}, 64'd1);
            checkOutput("bp_ovf", {63'd0, ovf}, 64'd1);
            a        = {$urandom(), $urandom()};
            b        = {$urandom(), $urandom()};
            in_valid = 1'($urandom_range(0, 1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_delivered", {63'd0, out_valid}, 64'd0);
        checkOutput("bp_ready_after", {63'd0, in_ready}, 64'd1);

        $display("[TB] reset during RUN");
        applyStimulus(64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b0, t1, ok);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("rstrun_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rstrun_sum", sum, 64'd0);
        checkOutput("rstrun_in_ready", {63'd0, in_ready}, 64'd0);
        checkOutput("rstrun_cout", {63'd0, cout}, 64'd0);
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        rst      = 1'b0;
        runOp("after_rst", 64'hDEAD_BEEF_DEAD_BEEF, 64'h1111_1111_1111_1111, 1'b0,
              64'hEFBE_D000_EFBE_D000, 1'b0, 1'b0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            if (n == 400) begin
                rst = 1'b1;
            end else begin
                rst = 1'b0;
            end
            in_valid  = ($urandom_range(0, 2) != 0);
            a         = pick_operand();
            b         = pick_operand();
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3 * NSLICE) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
